// File: rtl/hazard_pipe.sv
// Hazard tracking pipeline for a 5-stage MIPS-style core: follows GPR writes
// through E/M/W and produces stall enables, forwarding selects and a stall counter.
module hazard_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        isStall,
  input  logic        D_regW,
  input  logic [4:0]  D_regWa,
  input  logic [1:0]  D_Tnew,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  output logic        E_regW,
  output logic [4:0]  E_regWa,
  output logic [1:0]  E_Tnew,
  output logic        M_regW,
  output logic [4:0]  M_regWa,
  output logic [1:0]  M_Tnew,
  output logic        W_regW,
  output logic [4:0]  W_regWa,
  output logic        pcEn,
  output logic        fdEn,
  output logic        deClr,
  output logic [1:0]  D_fwdRs,
  output logic [1:0]  D_fwdRt,
  output logic [1:0]  E_fwdRs,
  output logic [1:0]  E_fwdRt,
  output logic        M_fwdRt,
  output logic [31:0] stallCnt
);

  logic        e_regw_r, m_regw_r, w_regw_r;
  logic [4:0]  e_regwa_r, m_regwa_r, w_regwa_r;
  logic [1:0]  e_tnew_r, m_tnew_r;
  logic [4:0]  e_rs_r, e_rt_r, m_rt_r;
  logic [31:0] stall_cnt_r;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    if (t == 2'd0) tnew_dec = 2'd0;
    else           tnew_dec = t - 2'd1;
  endfunction

  // D-stage select: 2 = E result, 1 = M result; the younger producer wins
  function automatic logic [1:0] d_sel(input logic [4:0] src,
                                       input logic ew, input logic [4:0] ewa, input logic [1:0] et,
                                       input logic mw, input logic [4:0] mwa, input logic [1:0] mt);
    if (src == 5'd0)                              d_sel = 2'd0;
    else if (ew && (ewa == src) && (et == 2'd0))  d_sel = 2'd2;
    else if (mw && (mwa == src) && (mt == 2'd0))  d_sel = 2'd1;
    else                                          d_sel = 2'd0;
  endfunction

  // E-stage select: 1 = M result, 2 = W result
  function automatic logic [1:0] e_sel(input logic [4:0] src,
                                       input logic mw, input logic [4:0] mwa, input logic [1:0] mt,
                                       input logic ww, input logic [4:0] wwa);
    if (src == 5'd0)                              e_sel = 2'd0;
    else if (mw && (mwa == src) && (mt == 2'd0))  e_sel = 2'd1;
    else if (ww && (wwa == src))                  e_sel = 2'd2;
    else                                          e_sel = 2'd0;
  endfunction

  // E stage: take the D instruction, or a bubble while stalled
  always_ff @(posedge clk) begin
    if (reset || isStall) begin
      e_regw_r  <= 1'b0;
      e_regwa_r <= 5'd0;
      e_tnew_r  <= 2'd0;
      e_rs_r    <= 5'd0;
      e_rt_r    <= 5'd0;
    end else begin
      e_regw_r  <= D_regW && (D_regWa != 5'd0);
      e_regwa_r <= D_regWa;
      e_tnew_r  <= tnew_dec(D_Tnew);
      e_rs_r    <= D_rs;
      e_rt_r    <= D_rt;
    end
  end

  // M and W stages advance every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      m_regw_r  <= 1'b0;
      m_regwa_r <= 5'd0;
      m_tnew_r  <= 2'd0;
      m_rt_r    <= 5'd0;
      w_regw_r  <= 1'b0;
      w_regwa_r <= 5'd0;
    end else begin
      m_regw_r  <= e_regw_r && (e_regwa_r != 5'd0);
      m_regwa_r <= e_regwa_r;
      m_tnew_r  <= tnew_dec(e_tnew_r);
      m_rt_r    <= e_rt_r;
      w_regw_r  <= m_regw_r && (m_regwa_r != 5'd0);
      w_regwa_r <= m_regwa_r;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (isStall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Zero-latency enables and forwarding selects
  always_comb begin
    pcEn    = ~isStall;
    fdEn    = ~isStall;
    deClr   = isStall;
    D_fwdRs = d_sel(D_rs, e_regw_r, e_regwa_r, e_tnew_r, m_regw_r, m_regwa_r, m_tnew_r);
    D_fwdRt = d_sel(D_rt, e_regw_r, e_regwa_r, e_tnew_r, m_regw_r, m_regwa_r, m_tnew_r);
    E_fwdRs = e_sel(e_rs_r, m_regw_r, m_regwa_r, m_tnew_r, w_regw_r, w_regwa_r);
    E_fwdRt = e_sel(e_rt_r, m_regw_r, m_regwa_r, m_tnew_r, w_regw_r, w_regwa_r);
    M_fwdRt = w_regw_r && (w_regwa_r == m_rt_r) && (m_rt_r != 5'd0);
  end

  assign E_regW   = e_regw_r;
  assign E_regWa  = e_regwa_r;
  assign E_Tnew   = e_tnew_r;
  assign M_regW   = m_regw_r;
  assign M_regWa  = m_regwa_r;
  assign M_Tnew   = m_tnew_r;
  assign W_regW   = w_regw_r;
  assign W_regWa  = w_regwa_r;
  assign stallCnt = stall_cnt_r;

endmodule
